// File: rtl/instr_fetch_unit.sv
// IF stage and IF/ID register: PC, instruction fetch, redirect and stall handling.
// Define JUMP_DELAY_SLOT_EN to keep the word after a jump (delay slot) instead of squashing it.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        jmp_eff;

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {pcp4_q[31:28], instr_q[25:0], 2'b00};
  assign jmp_eff     = jump & valid_q & ~stall;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    priority case (1'b1)
      // the branch is older than anything in IF/ID
      branch_taken: begin
        pc_d    = branch_target;
        instr_d = NOP_INSTR;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
      end
      jmp_eff: begin
        pc_d = jump_target;
`ifdef JUMP_DELAY_SLOT_EN
        instr_d = imem_rdata;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
`else
        instr_d = NOP_INSTR;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
`endif
      end
      stall: begin
        pc_d = pc_q;
      end
      default: begin
        pc_d    = pc_plus4;
        instr_d = imem_rdata;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign id_valid    = valid_q;
  assign id_instr    = instr_q;
  assign id_pc_plus4 = pcp4_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign imm         = instr_q[15:0];

endmodule
